// File: rtl/dm_regs.sv
// Debug-module register block: DMI request/response handshake in front of the
// dmcontrol / dmstatus / abstractcs / command / data0 registers and hart control.
module dm_regs #(
  parameter logic [31:0] HARTINFO_VALUE = 32'h0,
  parameter logic [3:0]  DM_VERSION     = 4'd2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_dmi_req_valid,
  output logic        o_dmi_req_ready,
  input  logic [6:0]  i_dmi_req_address,
  input  logic [31:0] i_dmi_req_data,
  input  logic [1:0]  i_dmi_req_op,
  output logic        o_dmi_rsp_valid,
  input  logic        i_dmi_rsp_ready,
  output logic [31:0] o_dmi_rsp_data,
  output logic [1:0]  o_dmi_rsp_op,
  output logic        o_dmactive,
  output logic        o_ndmreset,
  output logic        o_haltreq,
  output logic        o_resumereq,
  input  logic        i_halted,
  input  logic        i_running,
  output logic        o_cmd_valid,
  output logic [31:0] o_cmd,
  output logic [31:0] o_data0,
  input  logic        i_cmd_done,
  input  logic [2:0]  i_cmd_err,
  input  logic        i_data0_we,
  input  logic [31:0] i_data0
);

  localparam logic [6:0] ADDR_DATA0      = 7'h04;
  localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] ADDR_HARTINFO   = 7'h12;
  localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
  localparam logic [6:0] ADDR_COMMAND    = 7'h17;

  localparam logic [1:0] OP_NOP    = 2'd0;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_WRITE  = 2'd2;
  localparam logic [1:0] RSP_OK    = 2'd0;
  localparam logic [1:0] RSP_FAIL  = 2'd2;

  typedef enum logic {IDLE, RESP} state_t;

  state_t state, state_next;

  logic        accept, wr_en;
  logic [31:0] rd_data, wdata;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_op;

  logic        dmactive, ndmreset, haltreq, resumereq, resume_wait, resumeack;
  logic        cmd_valid, busy;
  logic [31:0] data0, cmd;
  logic [2:0]  cmderr;

  logic        dmactive_nx, ndmreset_nx, haltreq_nx, resumereq_nx, resume_wait_nx, resumeack_nx;
  logic        cmd_valid_nx, busy_nx;
  logic [31:0] data0_nx, cmd_nx;
  logic [2:0]  cmderr_nx;

  assign accept = (state == IDLE) && i_dmi_req_valid;
  assign wr_en  = accept && (i_dmi_req_op == OP_WRITE);
  assign wdata  = i_dmi_req_data;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (i_dmi_req_valid) state_next = RESP;
      RESP: if (i_dmi_rsp_ready) state_next = IDLE;
    endcase
  end

  always_comb begin
    o_dmi_req_ready = (state == IDLE);
    o_dmi_rsp_valid = (state == RESP);
  end

  always_comb begin
    rd_data = 32'h0;
    case (i_dmi_req_address)
      ADDR_DATA0:      rd_data = data0;
      ADDR_DMCONTROL:  rd_data = {haltreq, 29'b0, ndmreset, dmactive};
      ADDR_DMSTATUS:   rd_data = {14'b0, resumeack, resumeack, 4'b0, i_running, i_running,
                                  i_halted, i_halted, 1'b1, 3'b0, DM_VERSION};
      ADDR_HARTINFO:   rd_data = HARTINFO_VALUE;
      ADDR_ABSTRACTCS: rd_data = {19'b0, busy, 1'b0, cmderr, 4'b0, 4'd1};
      default:         rd_data = 32'h0;
    endcase
  end

  // The response is frozen at accept, so it reflects register values before this access.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rsp_data <= 32'h0;
      rsp_op   <= RSP_OK;
    end else if (accept) begin
      case (i_dmi_req_op)
        OP_READ: begin
          rsp_data <= rd_data;
          rsp_op   <= RSP_OK;
        end
        OP_NOP, OP_WRITE: begin
          rsp_data <= 32'h0;
          rsp_op   <= RSP_OK;
        end
        default: begin
          rsp_data <= 32'h0;
          rsp_op   <= RSP_FAIL;
        end
      endcase
    end
  end

  always_comb begin
    dmactive_nx    = dmactive;
    ndmreset_nx    = ndmreset;
    haltreq_nx     = haltreq;
    resumereq_nx   = 1'b0;
    resume_wait_nx = resume_wait;
    resumeack_nx   = resumeack;
    data0_nx       = data0;
    cmd_nx         = cmd;
    cmd_valid_nx   = 1'b0;
    busy_nx        = busy;
    cmderr_nx      = cmderr;

    // resumeack watches i_running only once the resume pulse has gone out
    if (resumereq) begin
      resume_wait_nx = 1'b1;
    end else if (resume_wait && i_running) begin
      resumeack_nx   = 1'b1;
      resume_wait_nx = 1'b0;
    end

    if (wr_en) begin
      case (i_dmi_req_address)
        ADDR_DMCONTROL: begin
          dmactive_nx = wdata[0];
          if (dmactive) begin
            haltreq_nx  = wdata[31];
            ndmreset_nx = wdata[1];
            if (wdata[30] && !wdata[31] && wdata[0]) begin
              resumereq_nx   = 1'b1;
              resumeack_nx   = 1'b0;
              resume_wait_nx = 1'b0;
            end
          end
        end
        ADDR_DATA0: begin
          if (dmactive) begin
            if (busy) begin
              if (cmderr == 3'd0) cmderr_nx = 3'd1;
            end else begin
              data0_nx = wdata;
            end
          end
        end
        ADDR_ABSTRACTCS: begin
          if (dmactive) cmderr_nx = cmderr & ~wdata[10:8];
        end
        ADDR_COMMAND: begin
          if (dmactive) begin
            if (busy) begin
              if (cmderr == 3'd0) cmderr_nx = 3'd1;
            end else if (cmderr == 3'd0) begin
              if (wdata[31:24] != 8'd0) begin
                cmderr_nx = 3'd2;
              end else if (!i_halted) begin
                cmderr_nx = 3'd4;
              end else begin
                cmd_nx       = wdata;
                busy_nx      = 1'b1;
                cmd_valid_nx = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end

    // Completion is applied after the DMI access so a hart error code wins over busy-error.
    if (i_cmd_done && busy) begin
      busy_nx = 1'b0;
      if (i_cmd_err != 3'd0) cmderr_nx = i_cmd_err;
      if (i_data0_we)        data0_nx  = i_data0;
    end

    if (!dmactive_nx) begin
      ndmreset_nx    = 1'b0;
      haltreq_nx     = 1'b0;
      resumereq_nx   = 1'b0;
      resume_wait_nx = 1'b0;
      resumeack_nx   = 1'b0;
      data0_nx       = 32'h0;
      cmd_nx         = 32'h0;
      cmd_valid_nx   = 1'b0;
      busy_nx        = 1'b0;
      cmderr_nx      = 3'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      dmactive    <= 1'b0;
      ndmreset    <= 1'b0;
      haltreq     <= 1'b0;
      resumereq   <= 1'b0;
      resume_wait <= 1'b0;
      resumeack   <= 1'b0;
      data0       <= 32'h0;
      cmd         <= 32'h0;
      cmd_valid   <= 1'b0;
      busy        <= 1'b0;
      cmderr      <= 3'd0;
    end else begin
      dmactive    <= dmactive_nx;
      ndmreset    <= ndmreset_nx;
      haltreq     <= haltreq_nx;
      resumereq   <= resumereq_nx;
      resume_wait <= resume_wait_nx;
      resumeack   <= resumeack_nx;
      data0       <= data0_nx;
      cmd         <= cmd_nx;
      cmd_valid   <= cmd_valid_nx;
      busy        <= busy_nx;
      cmderr      <= cmderr_nx;
    end
  end

  assign o_dmi_rsp_data = rsp_data;
  assign o_dmi_rsp_op   = rsp_op;
  assign o_dmactive     = dmactive;
  assign o_ndmreset     = ndmreset;
  assign o_haltreq      = haltreq;
  assign o_resumereq    = resumereq;
  assign o_cmd_valid    = cmd_valid;
  assign o_cmd          = cmd;
  assign o_data0        = data0;

endmodule

// File: tb/tb_dm_regs.sv
// Bench for dm_regs: directed vector table, hand-written corner sequences, then
// randomized DMI traffic checked against a transaction-level model of the register rules.
module tb_dm_regs;

  localparam logic [31:0] TB_HARTINFO = 32'h0021_1004;
  localparam logic [3:0]  TB_VERSION  = 4'd2;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_dmi_req_valid;
  logic        o_dmi_req_ready;
  logic [6:0]  i_dmi_req_address;
  logic [31:0] i_dmi_req_data;
  logic [1:0]  i_dmi_req_op;
  logic        o_dmi_rsp_valid;
  logic        i_dmi_rsp_ready;
  logic [31:0] o_dmi_rsp_data;
  logic [1:0]  o_dmi_rsp_op;
  logic        o_dmactive, o_ndmreset, o_haltreq, o_resumereq;
  logic        i_halted, i_running;
  logic        o_cmd_valid;
  logic [31:0] o_cmd, o_data0;
  logic        i_cmd_done;
  logic [2:0]  i_cmd_err;
  logic        i_data0_we;
  logic [31:0] i_data0;

  always #5 i_clk = ~i_clk;

  dm_regs #(.HARTINFO_VALUE(TB_HARTINFO), .DM_VERSION(TB_VERSION)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_dmi_req_valid(i_dmi_req_valid), .o_dmi_req_ready(o_dmi_req_ready),
    .i_dmi_req_address(i_dmi_req_address), .i_dmi_req_data(i_dmi_req_data),
    .i_dmi_req_op(i_dmi_req_op),
    .o_dmi_rsp_valid(o_dmi_rsp_valid), .i_dmi_rsp_ready(i_dmi_rsp_ready),
    .o_dmi_rsp_data(o_dmi_rsp_data), .o_dmi_rsp_op(o_dmi_rsp_op),
    .o_dmactive(o_dmactive), .o_ndmreset(o_ndmreset), .o_haltreq(o_haltreq),
    .o_resumereq(o_resumereq), .i_halted(i_halted), .i_running(i_running),
    .o_cmd_valid(o_cmd_valid), .o_cmd(o_cmd), .o_data0(o_data0),
    .i_cmd_done(i_cmd_done), .i_cmd_err(i_cmd_err), .i_data0_we(i_data0_we),
    .i_data0(i_data0)
  );

  int checks = 0;
  int failures = 0;

  // results captured by apply_stimulus
  logic        t_ok, t_quiet, t_cmd_pulse, t_resume_pulse;
  logic [31:0] t_rdata, t_cmd;
  logic [1:0]  t_rop;

  // transaction-level reference state
  logic        m_dmactive, m_ndm, m_halt, m_busy, m_ack;
  logic [31:0] m_data0, m_cmd;
  logic [2:0]  m_cmderr;

  typedef struct {
    logic        halted;
    logic        running;
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic        done;
    logic [31:0] done_data;
    logic [31:0] exp_data;
    logic [1:0]  exp_op;
    logic        exp_cmd;
  } vec_t;

  vec_t vecs[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic h, input logic r, input logic [6:0] a, input logic [1:0] op,
                         input logic [31:0] d, input logic dn, input logic [31:0] dd,
                         input logic [31:0] ed, input logic [1:0] eo, input logic ec);
    vecs.push_back('{h, r, a, op, d, dn, dd, ed, eo, ec});
  endtask

  // One DMI transaction with rsp_ready held high; entered and left at a falling edge.
  task automatic apply_stimulus(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                                input logic done, input logic [2:0] err, input logic we,
                                input logic [31:0] dd);
    i_dmi_req_valid = 1'b1;
    i_dmi_req_address = a;
    i_dmi_req_data = d;
    i_dmi_req_op = op;
    i_dmi_rsp_ready = 1'b1;
    i_cmd_done = done;
    i_cmd_err = err;
    i_data0_we = we;
    i_data0 = dd;
    @(posedge i_clk);
    @(negedge i_clk);
    i_dmi_req_valid = 1'b0;
    i_cmd_done = 1'b0;
    i_cmd_err = 3'd0;
    i_data0_we = 1'b0;
    t_ok = o_dmi_rsp_valid && !o_dmi_req_ready;
    t_rdata = o_dmi_rsp_data;
    t_rop = o_dmi_rsp_op;
    t_cmd_pulse = o_cmd_valid;
    t_cmd = o_cmd;
    t_resume_pulse = o_resumereq;
    @(posedge i_clk);
    @(negedge i_clk);
    t_quiet = !o_dmi_rsp_valid && o_dmi_req_ready && !o_cmd_valid && !o_resumereq;
  endtask

  task automatic pulse_done(input logic [2:0] err, input logic we, input logic [31:0] dd);
    i_cmd_done = 1'b1;
    i_cmd_err = err;
    i_data0_we = we;
    i_data0 = dd;
    @(posedge i_clk);
    @(negedge i_clk);
    i_cmd_done = 1'b0;
    i_cmd_err = 3'd0;
    i_data0_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      @(negedge i_clk);
    end
  endtask

  task automatic txn_read(input string name, input logic [6:0] a, input logic [31:0] exp);
    apply_stimulus(a, 2'd1, 32'h0, 1'b0, 3'd0, 1'b0, 32'h0);
    check_output({name, " handshake"}, {31'b0, t_ok}, 32'd1);
    check_output(name, t_rdata, exp);
  endtask

  task automatic txn_write(input logic [6:0] a, input logic [31:0] d);
    apply_stimulus(a, 2'd2, d, 1'b0, 3'd0, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] model_read(input logic [6:0] a, input logic h, input logic r);
    case (a)
      7'h04: return m_data0;
      7'h10: return (m_halt ? 32'h8000_0000 : 32'd0) + (m_ndm ? 32'd2 : 32'd0) + (m_dmactive ? 32'd1 : 32'd0);
      7'h11: return (m_ack ? 32'h3_0000 : 32'd0) + (r ? 32'hC00 : 32'd0) + (h ? 32'h300 : 32'd0)
                    + 32'h80 + {28'd0, TB_VERSION};
      7'h12: return TB_HARTINFO;
      7'h16: return (m_busy ? 32'h1000 : 32'd0) + ({29'd0, m_cmderr} << 8) + 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_dmactive = 1'b0; m_ndm = 1'b0; m_halt = 1'b0; m_busy = 1'b0; m_ack = 1'b0;
    m_data0 = 32'h0; m_cmd = 32'h0; m_cmderr = 3'd0;
  endtask

  task automatic model_write(input logic [6:0] a, input logic [31:0] d, input logic h, output logic exp_cmd);
    exp_cmd = 1'b0;
    case (a)
      7'h10: begin
        if (m_dmactive) begin
          m_halt = d[31];
          m_ndm = d[1];
        end
        m_dmactive = d[0];
      end
      7'h04: if (m_dmactive) begin
        if (m_busy) m_cmderr = (m_cmderr == 3'd0) ? 3'd1 : m_cmderr;
        else m_data0 = d;
      end
      7'h16: if (m_dmactive) m_cmderr = m_cmderr & ~d[10:8];
      7'h17: if (m_dmactive) begin
        if (m_busy) m_cmderr = (m_cmderr == 3'd0) ? 3'd1 : m_cmderr;
        else if (m_cmderr == 3'd0) begin
          if (d[31:24] != 8'd0) m_cmderr = 3'd2;
          else if (!h) m_cmderr = 3'd4;
          else begin
            m_busy = 1'b1;
            m_cmd = d;
            exp_cmd = 1'b1;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_done(input logic [2:0] err, input logic we, input logic [31:0] dd);
    if (m_busy) begin
      m_busy = 1'b0;
      if (err != 3'd0) m_cmderr = err;
      if (we) m_data0 = dd;
    end
  endtask

  task automatic model_settle();
    if (!m_dmactive) model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [6:0]  a;
    logic [1:0]  op;
    logic [31:0] d, dd, exp_rd;
    logic        conc, we, exp_cmd, pre_busy;
    logic [2:0]  err;
    string       nm;

    i_reset_n = 1'b0;
    i_dmi_req_valid = 1'b0; i_dmi_req_address = 7'h0; i_dmi_req_data = 32'h0; i_dmi_req_op = 2'd0;
    i_dmi_rsp_ready = 1'b1; i_halted = 1'b0; i_running = 1'b0;
    i_cmd_done = 1'b0; i_cmd_err = 3'd0; i_data0_we = 1'b0; i_data0 = 32'h0;
    #1;
    check_output("reset req_ready", {31'b0, o_dmi_req_ready}, 32'd1);
    check_output("reset rsp_valid", {31'b0, o_dmi_rsp_valid}, 32'd0);
    idle(2);
    check_output("reset outputs", {o_dmactive, o_ndmreset, o_haltreq, o_resumereq, o_cmd_valid}, 32'd0);
    check_output("reset data0", o_data0, 32'h0);
    i_reset_n = 1'b1;
    idle(1);

    add_vec(0, 0, 7'h10, 2'd1, 32'h0,          0, 32'h0,          32'h0,          2'd0, 0);
    add_vec(0, 0, 7'h11, 2'd1, 32'h0,          0, 32'h0,          32'h0000_0082,  2'd0, 0);
    add_vec(0, 0, 7'h04, 2'd2, 32'h1234_5678,  0, 32'h0,          32'h0,          2'd0, 0);
    add_vec(0, 0, 7'h04, 2'd1, 32'h0,          0, 32'h0,          32'h0,          2'd0, 0);
    add_vec(0, 0, 7'h10, 2'd2, 32'h0000_0001,  0, 32'h0,          32'h0,          2'd0, 0);
    add_vec(0, 1, 7'h11, 2'd1, 32'h0,          0, 32'h0,          32'h0000_0C82,  2'd0, 0);
    add_vec(0, 0, 7'h12, 2'd1, 32'h0,          0, 32'h0,          TB_HARTINFO,    2'd0, 0);
    add_vec(0, 0, 7'h16, 2'd1, 32'h0,          0, 32'h0,          32'h0000_0001,  2'd0, 0);
    add_vec(1, 0, 7'h17, 2'd2, 32'h0022_1000,  0, 32'h0,          32'h0,          2'd0, 1);
    add_vec(1, 0, 7'h16, 2'd1, 32'h0,          0, 32'h0,          32'h0000_1001,  2'd0, 0);
    add_vec(1, 0, 7'h17, 2'd2, 32'h0022_1000,  0, 32'h0,          32'h0,          2'd0, 0);
    add_vec(1, 0, 7'h16, 2'd1, 32'h0,          0, 32'h0,          32'h0000_1101,  2'd0, 0);
    add_vec(1, 0, 7'h04, 2'd1, 32'h0,          1, 32'hDEAD_BEEF,  32'hDEAD_BEEF,  2'd0, 0);
    add_vec(1, 0, 7'h16, 2'd1, 32'h0,          0, 32'h0,          32'h0000_0101,  2'd0, 0);
    add_vec(1, 0, 7'h17, 2'd2, 32'h0022_1000,  0, 32'h0,          32'h0,          2'd0, 0);
    add_vec(1, 0, 7'h16, 2'd2, 32'h0000_0700,  0, 32'h0,          32'h0,          2'd0, 0);
    add_vec(1, 0, 7'h16, 2'd1, 32'h0,          0, 32'h0,          32'h0000_0001,  2'd0, 0);
    add_vec(0, 0, 7'h17, 2'd2, 32'h0022_1000,  0, 32'h0,          32'h0,          2'd0, 0);
    add_vec(0, 0, 7'h16, 2'd1, 32'h0,          0, 32'h0,          32'h0000_0401,  2'd0, 0);
    add_vec(0, 0, 7'h16, 2'd2, 32'h0000_0400,  0, 32'h0,          32'h0,          2'd0, 0);
    add_vec(1, 0, 7'h17, 2'd2, 32'h0100_0000,  0, 32'h0,          32'h0,          2'd0, 0);
    add_vec(1, 0, 7'h16, 2'd1, 32'h0,          0, 32'h0,          32'h0000_0201,  2'd0, 0);
    add_vec(1, 0, 7'h16, 2'd2, 32'h0000_0700,  0, 32'h0,          32'h0,          2'd0, 0);
    add_vec(1, 0, 7'h04, 2'd3, 32'h1111_1111,  0, 32'h0,          32'h0,          2'd2, 0);
    add_vec(1, 0, 7'h04, 2'd1, 32'h0,          0, 32'h0,          32'hDEAD_BEEF,  2'd0, 0);
    add_vec(1, 0, 7'h10, 2'd2, 32'h8000_0003,  0, 32'h0,          32'h0,          2'd0, 0);
    add_vec(1, 0, 7'h10, 2'd1, 32'h0,          0, 32'h0,          32'h8000_0003,  2'd0, 0);
    add_vec(1, 0, 7'h13, 2'd1, 32'h0,          0, 32'h0,          32'h0,          2'd0, 0);
    add_vec(1, 0, 7'h12, 2'd2, 32'hFFFF_FFFF,  0, 32'h0,          32'h0,          2'd0, 0);
    add_vec(1, 0, 7'h12, 2'd1, 32'h0,          0, 32'h0,          TB_HARTINFO,    2'd0, 0);
    add_vec(1, 0, 7'h04, 2'd2, 32'hA5A5_0001,  0, 32'h0,          32'h0,          2'd0, 0);
    add_vec(1, 0, 7'h04, 2'd1, 32'h0,          0, 32'h0,          32'hA5A5_0001,  2'd0, 0);
    add_vec(1, 0, 7'h17, 2'd1, 32'h0,          0, 32'h0,          32'h0,          2'd0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      i_halted = vecs[i].halted;
      i_running = vecs[i].running;
      if (vecs[i].done) pulse_done(3'd0, 1'b1, vecs[i].done_data);
      apply_stimulus(vecs[i].addr, vecs[i].op, vecs[i].wdata, 1'b0, 3'd0, 1'b0, 32'h0);
      check_output($sformatf("vec%0d handshake", i), {31'b0, t_ok}, 32'd1);
      check_output($sformatf("vec%0d rsp_data", i), t_rdata, vecs[i].exp_data);
      check_output($sformatf("vec%0d rsp_op", i), {30'b0, t_rop}, {30'b0, vecs[i].exp_op});
      check_output($sformatf("vec%0d cmd_valid", i), {31'b0, t_cmd_pulse}, {31'b0, vecs[i].exp_cmd});
      if (vecs[i].exp_cmd) check_output($sformatf("vec%0d cmd", i), t_cmd, vecs[i].wdata);
      check_output($sformatf("vec%0d quiet", i), {31'b0, t_quiet}, 32'd1);
    end
    check_output("ctrl outputs", {o_dmactive, o_ndmreset, o_haltreq}, 32'd7);

    // Response held while the DTM stalls
    i_dmi_req_valid = 1'b1; i_dmi_req_address = 7'h10; i_dmi_req_op = 2'd1; i_dmi_rsp_ready = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_dmi_req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_output($sformatf("stall%0d rsp_valid", k), {31'b0, o_dmi_rsp_valid}, 32'd1);
      check_output($sformatf("stall%0d req_ready", k), {31'b0, o_dmi_req_ready}, 32'd0);
      check_output($sformatf("stall%0d rsp_data", k), o_dmi_rsp_data, 32'h8000_0003);
      @(posedge i_clk);
      @(negedge i_clk);
    end
    i_dmi_rsp_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    check_output("stall release", {30'b0, o_dmi_rsp_valid, o_dmi_req_ready}, 32'd1);

    // Resume request and resumeack
    i_halted = 1'b0; i_running = 1'b0;
    txn_write(7'h10, 32'h4000_0001);
    check_output("resume pulse", {31'b0, t_resume_pulse}, 32'd1);
    check_output("resume pulse end", {31'b0, t_quiet}, 32'd1);
    check_output("resume haltreq", {31'b0, o_haltreq}, 32'd0);
    txn_read("resumeack before run", 7'h11, 32'h0000_0082);
    i_running = 1'b1;
    idle(2);
    txn_read("resumeack set", 7'h11, 32'h0003_0C82);
    i_running = 1'b0;
    txn_write(7'h10, 32'h4000_0001);
    txn_read("resumeack cleared", 7'h11, 32'h0000_0082);

    // Completion coinciding with a rejected DMI write
    i_halted = 1'b1;
    txn_write(7'h17, 32'h0022_1000);
    check_output("conc cmd1", {31'b0, t_cmd_pulse}, 32'd1);
    apply_stimulus(7'h17, 2'd2, 32'h0022_1000, 1'b1, 3'd0, 1'b0, 32'h0);
    check_output("conc no cmd", {31'b0, t_cmd_pulse}, 32'd0);
    txn_read("conc cmderr1", 7'h16, 32'h0000_0101);
    txn_write(7'h16, 32'h0000_0700);
    txn_write(7'h17, 32'h0022_1000);
    check_output("conc cmd2", {31'b0, t_cmd_pulse}, 32'd1);
    apply_stimulus(7'h04, 2'd2, 32'h0000_0055, 1'b1, 3'd3, 1'b0, 32'h0);
    txn_read("conc cmderr3", 7'h16, 32'h0000_0301);
    txn_read("conc data0 kept", 7'h04, 32'hA5A5_0001);
    txn_write(7'h16, 32'h0000_0700);

    // Dropping dmactive abandons an in-flight command
    txn_write(7'h17, 32'h0022_1000);
    check_output("abandon cmd", {31'b0, t_cmd_pulse}, 32'd1);
    txn_write(7'h10, 32'h0000_0000);
    check_output("abandon dmactive", {31'b0, o_dmactive}, 32'd0);
    check_output("abandon o_cmd", o_cmd, 32'h0);
    txn_write(7'h10, 32'h0000_0001);
    pulse_done(3'd5, 1'b1, 32'hCAFE_F00D);
    txn_read("abandon data0", 7'h04, 32'h0);
    txn_read("abandon abstractcs", 7'h16, 32'h0000_0001);

    // Asynchronous reset while a response is pending
    i_dmi_req_valid = 1'b1; i_dmi_req_address = 7'h10; i_dmi_req_op = 2'd1;
    @(posedge i_clk);
    #2;
    check_output("pre-reset rsp_valid", {31'b0, o_dmi_rsp_valid}, 32'd1);
    i_reset_n = 1'b0;
    #1;
    check_output("async rsp_valid", {31'b0, o_dmi_rsp_valid}, 32'd0);
    check_output("async req_ready", {31'b0, o_dmi_req_ready}, 32'd1);
    check_output("async rsp_data", o_dmi_rsp_data, 32'h0);
    check_output("async dmactive", {31'b0, o_dmactive}, 32'd0);
    @(negedge i_clk);
    i_dmi_req_valid = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    txn_read("post-reset dmcontrol", 7'h10, 32'h0);

    // Randomized traffic against the reference model
    model_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        err = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'($urandom_range(1, 7));
        we = 1'($urandom_range(0, 1));
        dd = $urandom;
        pulse_done(err, we, dd);
        model_done(err, we, dd);
      end
      case ($urandom_range(0, 7))
        0: a = 7'h04;
        1, 2: a = 7'h10;
        3: a = 7'h11;
        4: a = 7'h12;
        5: a = 7'h16;
        6: a = 7'h17;
        default: a = 7'($urandom_range(0, 127));
      endcase
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) != 0) op = 2'd2;
      d = $urandom;
      if (a == 7'h10) begin
        d[30] = 1'b0;
        d[0] = ($urandom_range(0, 9) != 0);
      end
      if (a == 7'h17 && $urandom_range(0, 2) != 0) d[31:24] = 8'h00;
      i_halted = ($urandom_range(0, 3) != 0);
      i_running = 1'($urandom_range(0, 1));
      conc = ($urandom_range(0, 5) == 0);
      err = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'($urandom_range(1, 7));
      we = 1'($urandom_range(0, 1));
      dd = $urandom;

      exp_rd = (op == 2'd1) ? model_read(a, i_halted, i_running) : 32'd0;
      pre_busy = m_busy;
      exp_cmd = 1'b0;
      if (op == 2'd2) model_write(a, d, i_halted, exp_cmd);
      if (conc && pre_busy) begin
        m_busy = 1'b0;
        if (err != 3'd0) m_cmderr = err;
        if (we) m_data0 = dd;
      end
      model_settle();

      apply_stimulus(a, op, d, conc, err, we, dd);
      nm = $sformatf("rand%0d a=%h op=%0d", i, a, op);
      check_output({nm, " handshake"}, {31'b0, t_ok}, 32'd1);
      check_output({nm, " rsp_data"}, t_rdata, exp_rd);
      check_output({nm, " rsp_op"}, {30'b0, t_rop}, (op == 2'd3) ? 32'd2 : 32'd0);
      check_output({nm, " cmd_valid"}, {31'b0, t_cmd_pulse}, {31'b0, exp_cmd});
      check_output({nm, " resumereq"}, {31'b0, t_resume_pulse}, 32'd0);
      check_output({nm, " quiet"}, {31'b0, t_quiet}, 32'd1);
      check_output({nm, " ctrl"}, {29'b0, o_dmactive, o_ndmreset, o_haltreq}, {29'b0, m_dmactive, m_ndm, m_halt});
      check_output({nm, " data0"}, o_data0, m_data0);
      check_output({nm, " cmd"}, o_cmd, m_cmd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
